// File: rtl/fifo_128b_unpack32_pkg.sv
// Shared widths and FSM encoding for the C2C receive drain/pack stages.
package fifo_128b_unpack32_pkg;

    localparam int C2C_WORD_W         = 128;
    localparam int C2C_BEAT_W         = 32;
    localparam int C2C_BEATS_PER_WORD = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/c2c_frame_cnt.sv
// Frame beat counter: flags the last beat of every FRAME_BEATS-beat frame.
// Latency: last is combinational from the registered count; stalls hold the count.
// Backpressure: advances only on accepted beats (vld & rdy).
module c2c_frame_cnt #(
    parameter int FRAME_BEATS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beat_vld,
    input  logic beat_rdy,
    output logic beat_last
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_BEATS - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        at_last;

    assign at_last   = (cnt_q == LAST_IDX);
    assign beat_last = beat_vld & at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (beat_vld && beat_rdy) begin
            cnt_d = at_last ? 16'd0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_128b_unpack32.sv
// Drains the 128-bit C2C receive FIFO and unpacks each word into four 32-bit beats.
// Latency: EMPTY low in cycle k gives O_VALID in cycle k+1; full rate, no inter-word bubble.
// Backpressure: O_READY low freezes all outputs; the next pop waits for the last beat's accept.
module fifo_128b_unpack32
    import fifo_128b_unpack32_pkg::*;
#(
    parameter int FRAME_BEATS = 16,
    parameter bit LANE_SWAP   = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  I_ENABLE,
    output logic                  RDEN,
    input  logic [C2C_WORD_W-1:0] RDATA,
    input  logic                  EMPTY,
    output logic                  O_VALID,
    input  logic                  O_READY,
    output logic [C2C_BEAT_W-1:0] O_DATA,
    output logic                  O_LAST,
    output logic                  O_BUSY,
    output logic [31:0]           O_WCNT
);

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [C2C_WORD_W-1:0] hold_q, hold_d;
    logic [31:0]           wcnt_q, wcnt_d;

    logic       beat_acc;
    logic       pop;
    logic [1:0] lane_sel;

    assign O_VALID  = (state_q == ST_SHIFT);
    assign O_BUSY   = (state_q == ST_SHIFT);
    assign O_WCNT   = wcnt_q;
    assign beat_acc = O_VALID & O_READY;

    // Pop either from idle or on the accepted last beat, so words stream without a gap.
    assign pop  = RST_N & I_ENABLE & ~EMPTY &
                  ((state_q == ST_IDLE) | ((idx_q == 2'd3) & beat_acc));
    assign RDEN = pop;

    assign lane_sel = LANE_SWAP ? ~idx_q : idx_q;
    assign O_DATA   = O_VALID ? hold_q[{lane_sel, 5'b00000} +: C2C_BEAT_W] : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        wcnt_d  = wcnt_q;
        if (pop) begin
            state_d = ST_SHIFT;
            idx_d   = 2'd0;
            hold_d  = RDATA;
            wcnt_d  = wcnt_q + 32'd1;
        end else if (beat_acc) begin
            if (idx_q == 2'd3) begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end else begin
                idx_d   = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            hold_q  <= '0;
            wcnt_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            wcnt_q  <= wcnt_d;
        end
    end

    c2c_frame_cnt #(
        .FRAME_BEATS(FRAME_BEATS)
    ) u_frame_cnt (
        .clk      (CLK),
        .rst_n    (RST_N),
        .beat_vld (O_VALID),
        .beat_rdy (O_READY),
        .beat_last(O_LAST)
    );

endmodule

// File: tb/tb_fifo_128b_unpack32.sv
// Bench: two instances (FRAME_BEATS=16/LSB-first and FRAME_BEATS=1/MSB-first) share one FIFO
// model; expected beats come from a queue of lanes of popped words.
module tb_fifo_128b_unpack32;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         ready;
    logic [127:0] rdata;
    logic         empty;

    logic         rden_a, vld_a, last_a, busy_a;
    logic [31:0]  data_a, wcnt_a;
    logic         rden_b, vld_b, last_b, busy_b;
    logic [31:0]  data_b, wcnt_b;

    fifo_128b_unpack32 #(.FRAME_BEATS(16), .LANE_SWAP(1'b0)) dut (
        .CLK(clk), .RST_N(rst_n), .I_ENABLE(en), .RDEN(rden_a), .RDATA(rdata),
        .EMPTY(empty), .O_VALID(vld_a), .O_READY(ready), .O_DATA(data_a),
        .O_LAST(last_a), .O_BUSY(busy_a), .O_WCNT(wcnt_a)
    );

    fifo_128b_unpack32 #(.FRAME_BEATS(1), .LANE_SWAP(1'b1)) dut_b (
        .CLK(clk), .RST_N(rst_n), .I_ENABLE(en), .RDEN(rden_b), .RDATA(rdata),
        .EMPTY(empty), .O_VALID(vld_b), .O_READY(ready), .O_DATA(data_b),
        .O_LAST(last_b), .O_BUSY(busy_b), .O_WCNT(wcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] fifo_q[$];
    logic [31:0]  exp_q[$];
    logic [31:0]  expb_q[$];
    int           acc_cnt = 0;
    logic [31:0]  exp_wcnt = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic upd_pins();
        empty = (fifo_q.size() == 0);
        rdata = empty ? 128'd0 : fifo_q[0];
    endtask

    task automatic push(input logic [127:0] w);
        fifo_q.push_back(w);
        upd_pins();
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic cycle(input logic r, input logic e, input logic n);
        logic         exp_vld;
        logic         exp_rden;
        logic [127:0] w;
        @(negedge clk);
        ready = r;
        en    = e;
        rst_n = n;
        #1;
        exp_vld  = (exp_q.size() > 0);
        exp_rden = n && e && !empty && (exp_q.size() == 0 || (exp_q.size() == 1 && r));
        check_eq("rden_a", 32'(rden_a), 32'(exp_rden));
        check_eq("rden_b", 32'(rden_b), 32'(exp_rden));
        check_eq("valid_a", 32'(vld_a), 32'(exp_vld));
        check_eq("valid_b", 32'(vld_b), 32'(exp_vld));
        check_eq("busy_a", 32'(busy_a), 32'(exp_vld));
        check_eq("wcnt_a", wcnt_a, exp_wcnt);
        check_eq("wcnt_b", wcnt_b, exp_wcnt);
        if (exp_vld) begin
            check_eq("data_a", data_a, exp_q[0]);
            check_eq("data_b", data_b, expb_q[0]);
            check_eq("last_a", 32'(last_a), 32'(acc_cnt == 15));
            check_eq("last_b", 32'(last_b), 32'd1);
        end else begin
            check_eq("last_a_idle", 32'(last_a), 32'd0);
            check_eq("last_b_idle", 32'(last_b), 32'd0);
        end
        @(posedge clk);
        #1;
        if (!n) begin
            fifo_q.delete();
            exp_q.delete();
            expb_q.delete();
            acc_cnt  = 0;
            exp_wcnt = 32'd0;
        end else begin
            if (exp_vld && r) begin
                void'(exp_q.pop_front());
                void'(expb_q.pop_front());
                acc_cnt = (acc_cnt + 1) % 16;
            end
            if (exp_rden) begin
                w = fifo_q.pop_front();
                for (int i = 0; i < 4; i++) begin
                    exp_q.push_back(w[32*i +: 32]);
                    expb_q.push_back(w[127-32*i -: 32]);
                end
                exp_wcnt = exp_wcnt + 32'd1;
            end
        end
        upd_pins();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("rst_data_a", data_a, 32'd0);
        check_eq("rst_valid_a", 32'(vld_a), 32'd0);
        check_eq("rst_busy_b", 32'(busy_b), 32'd0);
        check_eq("rst_wcnt_a", wcnt_a, 32'd0);
        check_eq("rst_rden_a", 32'(rden_a), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        ready = 1'b0;
        upd_pins();
        repeat (2) do_reset();

        // Single word, LSB lane first.
        push(128'h44444444_33333333_22222222_11111111);
        repeat (7) cycle(1'b1, 1'b1, 1'b1);
        check_eq("single_wcnt", wcnt_a, 32'd1);

        // Back-to-back: eight preloaded words, frame of 16 beats.
        do_reset();
        for (int i = 0; i < 8; i++) push({4{$urandom}} ^ {96'd0, 32'(i)});
        repeat (36) cycle(1'b1, 1'b1, 1'b1);
        check_eq("b2b_wcnt", wcnt_a, 32'd8);

        // Backpressure on beats 1 and 3, a second word waiting.
        do_reset();
        push({$urandom, $urandom, $urandom, $urandom});
        push({$urandom, $urandom, $urandom, $urandom});
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        repeat (6) cycle(1'b1, 1'b1, 1'b1);

        // Empty FIFO, then enable dropped mid-word with words queued.
        do_reset();
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push({$urandom, $urandom, $urandom, $urandom});
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (6) cycle(1'b1, 1'b0, 1'b1);
        check_eq("en_hold_wcnt", wcnt_a, 32'd1);
        repeat (12) cycle(1'b1, 1'b1, 1'b1);

        // Reset at beat index 2.
        do_reset();
        push({$urandom, $urandom, $urandom, $urandom});
        push({$urandom, $urandom, $urandom, $urandom});
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b1, 1'b1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 6)
                push({$urandom, $urandom, $urandom, $urandom});
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 299) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
